// File: rtl/frame_pingpong_buffer.sv
// Two-bank frame buffer: the producer fills one bank while the consumer drains the other.
// Elements arrive y-fastest and leave in the same order, tagged with (x, y) and end-of-frame.
module frame_pingpong_buffer #(
   parameter int SIZE_X = 100,
   parameter int SIZE_Y = 10,
   parameter int DATA_W = 32,
   parameter int X_W    = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
   parameter int Y_W    = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [X_W-1:0]    out_x,
   output logic [Y_W-1:0]    out_y,
   output logic              out_last,
   output logic [1:0]        bank_full,
   output logic [15:0]       frame_count
);

   localparam int DEPTH = SIZE_X * SIZE_Y;
   localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(SIZE_X - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SIZE_Y - 1);

   logic [DATA_W-1:0] mem [2][DEPTH];

   logic              wb_q, wb_d, rb_q, rb_d;
   logic [X_W-1:0]    wx_q, wx_d, rx_q, rx_d;
   logic [Y_W-1:0]    wy_q, wy_d, ry_q, ry_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [X_W-1:0]    out_x_q, out_x_d;
   logic [Y_W-1:0]    out_y_q, out_y_d;
   logic              out_last_q, out_last_d;
   logic [15:0]       frame_count_q, frame_count_d;

   logic           wr_acc, wr_last, rd_load, rd_last;
   logic [A_W-1:0] wr_addr, rd_addr;

   assign in_ready    = !bank_full_q[wb_q];
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_x       = out_x_q;
   assign out_y       = out_y_q;
   assign out_last    = out_last_q;
   assign bank_full   = bank_full_q;
   assign frame_count = frame_count_q;

   always_comb begin
      // A write presented alongside flush is dropped, not stored.
      wr_acc  = in_valid && in_ready && !flush;
      wr_last = (wx_q == X_LAST) && (wy_q == Y_LAST);
      rd_load = bank_full_q[rb_q] && (!out_valid_q || out_ready);
      rd_last = (rx_q == X_LAST) && (ry_q == Y_LAST);
      wr_addr = A_W'(wx_q) * A_W'(SIZE_Y) + A_W'(wy_q);
      rd_addr = A_W'(rx_q) * A_W'(SIZE_Y) + A_W'(ry_q);
   end

   always_comb begin
      wb_d = wb_q;
      wx_d = wx_q;
      wy_d = wy_q;
      if (flush) begin
         wx_d = '0;
         wy_d = '0;
      end else if (wr_acc) begin
         if (wr_last) begin
            wx_d = '0;
            wy_d = '0;
            wb_d = ~wb_q;
         end else if (wy_q == Y_LAST) begin
            wy_d = '0;
            wx_d = wx_q + 1'b1;
         end else begin
            wy_d = wy_q + 1'b1;
         end
      end
   end

   always_comb begin
      rb_d        = rb_q;
      rx_d        = rx_q;
      ry_d        = ry_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_last_d  = out_last_q;
      if (rd_load) begin
         out_valid_d = 1'b1;
         out_data_d  = mem[rb_q][rd_addr];
         out_x_d     = rx_q;
         out_y_d     = ry_q;
         out_last_d  = rd_last;
         if (rd_last) begin
            rx_d = '0;
            ry_d = '0;
            rb_d = ~rb_q;
         end else if (ry_q == Y_LAST) begin
            ry_d = '0;
            rx_d = rx_q + 1'b1;
         end else begin
            ry_d = ry_q + 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      // Reader and writer never target the same bank here: a load needs the
      // bank full, a write needs it empty.
      bank_full_d = bank_full_q;
      if (rd_load && rd_last) bank_full_d[rb_q] = 1'b0;
      if (wr_acc && wr_last)  bank_full_d[wb_q] = 1'b1;
      frame_count_d = frame_count_q + 16'(out_valid_q && out_ready && out_last_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_q          <= 1'b0;
         wx_q          <= '0;
         wy_q          <= '0;
         rb_q          <= 1'b0;
         rx_q          <= '0;
         ry_q          <= '0;
         bank_full_q   <= 2'b00;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_x_q       <= '0;
         out_y_q       <= '0;
         out_last_q    <= 1'b0;
         frame_count_q <= '0;
      end else begin
         wb_q          <= wb_d;
         wx_q          <= wx_d;
         wy_q          <= wy_d;
         rb_q          <= rb_d;
         rx_q          <= rx_d;
         ry_q          <= ry_d;
         bank_full_q   <= bank_full_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_x_q       <= out_x_d;
         out_y_q       <= out_y_d;
         out_last_q    <= out_last_d;
         frame_count_q <= frame_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) mem[wb_q][wr_addr] <= in_data;
   end

endmodule
